param_uart: RTL and testbench

PARAM_UART -- requirements
Module: param_uart

---
 rtl/param_uart.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_param_uart.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/param_uart.sv
// Parameterised full-duplex UART: independent TX and RX engines sharing only the clock
// and reset. Each bit period is exactly CLK_FREQ/BAUDRATE clocks.
//
// state   | meaning
// R_IDLE  | line idle, waiting for a low level on the synchronised rx
// R_START | half a bit period into the start bit, confirming it is still low
// R_DATA  | sampling payload bits LSB first, one per bit period
// R_PAR   | sampling the parity bit (only when PARITY != 0)
// R_STOP  | sampling the single checked stop bit
// R_BRK   | stop bit was low; waiting for the line to return high
// T_IDLE  | transmitter free, tx_ready high, line held at 1
// T_START | driving the start bit (0)
// T_DATA  | driving payload bits LSB first
// T_PAR   | driving the parity bit (only when PARITY != 0)
// T_STOP  | driving STOP_BITS stop bits (1)
module param_uart #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUDRATE  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int DIV = CLK_FREQ / BAUDRATE;
    localparam int CW  = $clog2(DIV + 1);

    localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (DIV < 4) begin : g_bad_div
        $error("param_uart: CLK_FREQ/BAUDRATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("param_uart: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("param_uart: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("param_uart: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PAR, T_STOP
    } tx_state_t;

    // ---------------- receiver ----------------
    logic                 rx_s1, rx_s2;
    rx_state_t            r_state, r_state_nx;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_sr;
    logic                 r_par_bit;
    logic                 r_tc, r_ld_half, r_ld_full, r_shift, r_par_cap, r_done;
    logic                 r_par_calc, r_perr_nx;

    assign r_tc       = (r_cnt == '0);
    assign r_par_calc = (^r_sr) ^ r_par_bit;
    assign r_perr_nx  = (PARITY == 1) ? ~r_par_calc :
                        (PARITY == 2) ?  r_par_calc : 1'b0;

    always_comb begin
        r_state_nx = r_state;
        r_ld_half  = 1'b0;
        r_ld_full  = 1'b0;
        r_shift    = 1'b0;
        r_par_cap  = 1'b0;
        r_done     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (!rx_s2) begin
                    r_state_nx = R_START;
                    r_ld_half  = 1'b1;
                end
            end
            R_START: begin
                if (r_tc) begin
                    if (rx_s2) begin
                        r_state_nx = R_IDLE;
                    end else begin
                        r_state_nx = R_DATA;
                        r_ld_full  = 1'b1;
                    end
                end
            end
            R_DATA: begin
                if (r_tc) begin
                    r_shift   = 1'b1;
                    r_ld_full = 1'b1;
                    if (r_bit == LAST_DATA) begin
                        r_state_nx = (PARITY != 0) ? R_PAR : R_STOP;
                    end
                end
            end
            R_PAR: begin
                if (r_tc) begin
                    r_par_cap  = 1'b1;
                    r_ld_full  = 1'b1;
                    r_state_nx = R_STOP;
                end
            end
            R_STOP: begin
                if (r_tc) begin
                    r_done     = 1'b1;
                    r_state_nx = rx_s2 ? R_IDLE : R_BRK;
                end
            end
            R_BRK: begin
                if (rx_s2) begin
                    r_state_nx = R_IDLE;
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            r_state       <= R_IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_sr          <= '0;
            r_par_bit     <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            r_state <= r_state_nx;

            if (r_ld_half) begin
                r_cnt <= HALF_M1;
            end else if (r_ld_full) begin
                r_cnt <= DIV_M1;
            end else if (!r_tc) begin
                r_cnt <= r_cnt - CNT_ONE;
            end

            if (r_state == R_START) begin
                r_bit <= '0;
            end else if (r_shift) begin
                r_bit <= r_bit + 4'd1;
            end

            if (r_shift) begin
                r_sr <= {rx_s2, r_sr[DATA_BITS-1:1]};
            end
            if (r_par_cap) begin
                r_par_bit <= rx_s2;
            end

            // Error flags are qualified by the done strobe so they read 0 between frames.
            rx_valid      <= r_done;
            rx_parity_err <= r_done & r_perr_nx;
            rx_frame_err  <= r_done & ~rx_s2;
            if (r_done) begin
                rx_data <= r_sr;
            end
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t            t_state, t_state_nx;
    logic [CW-1:0]        t_cnt;
    logic [3:0]           t_bit;
    logic [DATA_BITS-1:0] t_sr;
    logic                 t_par, t_par_nx;
    logic                 t_tc, t_load, t_ld_full, t_shift, t_bit_clr, t_bit_inc;
    logic                 tx_nx;

    assign t_tc     = (t_cnt == '0);
    assign t_par_nx = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
    assign tx_ready = (t_state == T_IDLE);

    // tx is registered; tx_nx selects the level of the bit being entered.
    always_comb begin
        t_state_nx = t_state;
        t_load     = 1'b0;
        t_ld_full  = 1'b0;
        t_shift    = 1'b0;
        t_bit_clr  = 1'b0;
        t_bit_inc  = 1'b0;
        tx_nx      = tx;
        case (t_state)
            T_IDLE: begin
                tx_nx = 1'b1;
                if (tx_valid) begin
                    t_load     = 1'b1;
                    t_ld_full  = 1'b1;
                    t_state_nx = T_START;
                    tx_nx      = 1'b0;
                end
            end
            T_START: begin
                if (t_tc) begin
                    t_ld_full  = 1'b1;
                    t_state_nx = T_DATA;
                    tx_nx      = t_sr[0];
                end
            end
            T_DATA: begin
                if (t_tc) begin
                    t_ld_full = 1'b1;
                    t_shift   = 1'b1;
                    if (t_bit == LAST_DATA) begin
                        t_bit_clr = 1'b1;
                        if (PARITY != 0) begin
                            t_state_nx = T_PAR;
                            tx_nx      = t_par;
                        end else begin
                            t_state_nx = T_STOP;
                            tx_nx      = 1'b1;
                        end
                    end else begin
                        t_bit_inc = 1'b1;
                        tx_nx     = t_sr[1];
                    end
                end
            end
            T_PAR: begin
                if (t_tc) begin
                    t_ld_full  = 1'b1;
                    t_state_nx = T_STOP;
                    tx_nx      = 1'b1;
                end
            end
            T_STOP: begin
                if (t_tc) begin
                    tx_nx = 1'b1;
                    if (t_bit == LAST_STOP) begin
                        t_bit_clr  = 1'b1;
                        t_state_nx = T_IDLE;
                    end else begin
                        t_bit_inc = 1'b1;
                        t_ld_full = 1'b1;
                    end
                end
            end
            default: begin
                t_state_nx = T_IDLE;
                tx_nx      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            t_state <= T_IDLE;
            t_cnt   <= '0;
            t_bit   <= '0;
            t_sr    <= '0;
            t_par   <= 1'b0;
            tx      <= 1'b1;
        end else begin
            t_state <= t_state_nx;
            tx      <= tx_nx;

            if (t_ld_full) begin
                t_cnt <= DIV_M1;
            end else if (!t_tc) begin
                t_cnt <= t_cnt - CNT_ONE;
            end

            if (t_bit_clr) begin
                t_bit <= '0;
            end else if (t_bit_inc) begin
                t_bit <= t_bit + 4'd1;
            end

            if (t_load) begin
                t_sr  <= tx_data;
                t_par <= t_par_nx;
            end else if (t_shift) begin
                t_sr <= t_sr >> 1;
            end
        end
    end

endmodule

// File: tb/tb_param_uart.sv
// Directed bench for param_uart at DIV=16, 8 data bits, even parity, one stop bit.
module tb_param_uart;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       rx_drv = 1'b1;
    logic       lb = 1'b0;
    logic       rx_in;
    logic       tx;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    int         rv_cnt = 0;
    int         flag_viol = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;

    assign rx_in = lb ? tx : rx_drv;

    always #5 clk = ~clk;

    param_uart #(
        .CLK_FREQ (16),
        .BAUDRATE (1),
        .DATA_BITS(8),
        .PARITY   (2),
        .STOP_BITS(1)
    ) dut (
        .clk          (clk),
        .arstn        (arstn),
        .rx           (rx_in),
        .tx           (tx),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err)
    );

    // Receive monitor: records every rx_valid pulse and any error flag raised outside one.
    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt    = rv_cnt + 1;
            prev_data = last_data;
            last_data = rx_data;
            last_perr = rx_parity_err;
            last_ferr = rx_frame_err;
        end else if (rx_parity_err || rx_frame_err) begin
            flag_viol = flag_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one 8E1-style frame on rx with an explicit parity and stop level.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = p;
        repeat (16) @(negedge clk);
        rx_drv = stop;
        repeat (16) @(negedge clk);
    endtask

    logic [10:0] exp_bits;
    int          low_cnt;
    int          base;
    bit          done;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_flags", {rx_parity_err, rx_frame_err}, 0);
        arstn = 1'b1;
        repeat (4) @(negedge clk);

        // TX 0xA5, even parity: 0,1,0,1,0,0,1,0,1,0,1 (start first)
        exp_bits = 11'b10101001010;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        low_cnt = 0;
        done    = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                tx_valid = 1'b0;
                tx_data  = 8'hFF;
            end
            if (c == 20) begin
                tx_valid = 1'b1;
                tx_data  = 8'h00;
            end
            if (c == 30) tx_valid = 1'b0;
            if (tx_ready) done = 1'b1;
            else low_cnt = low_cnt + 1;
            if ((c % 16) == 8 && c < 176)
                chk($sformatf("tx_bit%0d", c / 16), tx, exp_bits[c / 16]);
        end
        chk("tx_ready_low", low_cnt, 176);
        repeat (20) @(negedge clk);
        chk("tx_no_queue_ready", tx_ready, 1);
        chk("tx_no_queue_line", tx, 1);

        // Loopback 0x3C
        lb       = 1'b1;
        base     = rv_cnt;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (230) @(negedge clk);
        lb = 1'b0;
        chk("lb_count", rv_cnt - base, 1);
        chk("lb_data", last_data, 8'h3C);
        chk("lb_perr", last_perr, 0);
        chk("lb_ferr", last_ferr, 0);

        // Parity error: 0x01 carries parity 0 under even parity
        base = rv_cnt;
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (30) @(negedge clk);
        chk("par_count", rv_cnt - base, 1);
        chk("par_data", last_data, 8'h01);
        chk("par_perr", last_perr, 1);
        chk("par_ferr", last_ferr, 0);

        // Framing error followed by a held-low line
        base = rv_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("brk_count", rv_cnt - base, 1);
        chk("brk_data", last_data, 8'h55);
        chk("brk_ferr", last_ferr, 1);
        chk("brk_perr", last_perr, 0);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        chk("brk_no_extra", rv_cnt - base, 1);
        send_frame(8'h96, 1'b0, 1'b1);
        repeat (30) @(negedge clk);
        chk("post_brk_count", rv_cnt - base, 2);
        chk("post_brk_data", last_data, 8'h96);
        chk("post_brk_ferr", last_ferr, 0);

        // Back-to-back frames with no idle gap
        base = rv_cnt;
        send_frame(8'hA3, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (30) @(negedge clk);
        chk("b2b_count", rv_cnt - base, 2);
        chk("b2b_first", prev_data, 8'hA3);
        chk("b2b_second", last_data, 8'h5A);

        // Short glitch on idle line
        base   = rv_cnt;
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_no_valid", rv_cnt - base, 0);

        // Reset in the middle of a TX frame and an RX frame
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        rx_drv   = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_busy", tx_ready, 0);
        chk("mid_tx_low", tx, 0);
        base   = rv_cnt;
        arstn  = 1'b0;
        rx_drv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_tx", tx, 1);
        arstn = 1'b1;
        @(negedge clk);
        chk("rel_tx", tx, 1);
        chk("rel_tx_ready", tx_ready, 1);
        repeat (250) @(negedge clk);
        chk("rst_no_rx_valid", rv_cnt - base, 0);
        chk("rst_tx_idle", tx, 1);

        chk("flags_outside_valid", flag_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
